gray2bin_mc: RTL and testbench

- Multi-channel, pipelined Gray/binary converter for square-QAM I/Q axis labels.
- Generalises the fixed-order gray2bin in five ways:
  - NUM_CH parallel channels.
  - Modulation order selectable per beat at runtime (QPSK..256QAM).
  - Selectable direction (Gray->binary or binary->Gray).
  - Valid/ready backpressure.
  - Illegal-label error flagging with a saturating error counter.
- Sits between the symbol demapper/slicer and the bit de-interleaver.

---
 rtl/gray2bin_mc.sv | 203 ++++++++++++++++++++
 tb/tb_gray2bin_mc.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray2bin_mc.sv
// ---------------------------------------------------------------------------
// gray2bin_mc
//
// Multi-channel, pipelined Gray <-> binary converter for square-QAM I/Q axis
// labels. It sits between the symbol slicer and the bit de-interleaver. Each
// beat carries NUM_CH channels of I and Q labels, plus a per-beat modulation
// order and conversion direction. Beats flow through a two-stage elastic
// pipeline with valid/ready handshaking. Labels that use bits above the
// active order are flagged and zeroed. A saturating counter records how many
// output beats carried at least one flagged channel.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : asynchronous reset, active low
//   i_dv       : input beat valid
//   o_rdy      : block can accept a beat this cycle
//   i_mode     : bits per axis k = i_mode + 1 (QPSK .. 256QAM)
//   i_dir      : 0 = Gray->binary, 1 = binary->Gray
//   i_code_i/q : input labels, channel c at [c*W +: W], LSB aligned
//   o_dv       : output beat valid
//   i_rdy      : downstream accepts the output beat
//   o_code_i/q : converted labels
//   o_err      : per-channel illegal-label flag, aligned with o_dv
//   i_err_clr  : synchronous clear of o_err_cnt
//   o_err_cnt  : saturating count of output beats with any o_err bit set
// ---------------------------------------------------------------------------
module gray2bin_mc #(
   parameter int MAX_ORDER = 256,
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 16,
   localparam int W        = $clog2(MAX_ORDER) / 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_dv,
   output logic                  o_rdy,
   input  logic [1:0]            i_mode,
   input  logic                  i_dir,
   input  logic [NUM_CH*W-1:0]   i_code_i,
   input  logic [NUM_CH*W-1:0]   i_code_q,
   output logic                  o_dv,
   input  logic                  i_rdy,
   output logic [NUM_CH*W-1:0]   o_code_i,
   output logic [NUM_CH*W-1:0]   o_code_q,
   output logic [NUM_CH-1:0]     o_err,
   input  logic                  i_err_clr,
   output logic [CNT_W-1:0]      o_err_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Stage 1: raw beat and its sideband
   logic                  v1_q, v1_d;
   logic [1:0]            mode1_q, mode1_d;
   logic                  dir1_q, dir1_d;
   logic [NUM_CH*W-1:0]   ci1_q, ci1_d;
   logic [NUM_CH*W-1:0]   cq1_q, cq1_d;

   // Stage 2: converted result
   logic                  v2_q, v2_d;
   logic [NUM_CH*W-1:0]   oi2_q, oi2_d;
   logic [NUM_CH*W-1:0]   oq2_q, oq2_d;
   logic [NUM_CH-1:0]     err2_q, err2_d;

   logic [CNT_W-1:0]      cnt_q, cnt_d;

   // Handshake helpers
   logic                  s2_free;
   logic                  s1_adv;
   logic                  accept;

   // Conversion datapath between the stages
   logic [2:0]            k;
   logic [W-1:0]          act_mask;
   logic [W-1:0]          ch_i, ch_q;
   logic [NUM_CH*W-1:0]   conv_i, conv_q;
   logic [NUM_CH-1:0]     conv_err;

   // Inputs are guaranteed zero above the active k bits when this is used,
   // so a full-width prefix XOR from the MSB gives the same result as one
   // that starts at bit k-1, and likewise for the binary->Gray form.
   function automatic logic [W-1:0] convert(input logic [W-1:0] x,
                                            input logic dir);
      logic [W-1:0] r;
      r = '0;
      if (dir) begin
         r = x ^ (x >> 1);
      end else begin
         r[W-1] = x[W-1];
         for (int j = W - 2; j >= 0; j--) begin
            r[j] = r[j+1] ^ x[j];
         end
      end
      return r;
   endfunction

   // Stage 2 can take a new beat when it is empty or draining this cycle;
   // stage 1 then advances, and stage 1 can refill in the same cycle.
   always_comb begin
      s2_free = !v2_q || i_rdy;
      s1_adv  = v1_q && s2_free;
      o_rdy   = !v1_q || s2_free;
      accept  = i_dv && o_rdy;
   end

   // Per-channel conversion of the beat held in stage 1. An unsupported
   // order flags every channel; otherwise only channels with stray high
   // bits are flagged. Flagged channels produce zeros on both axes.
   always_comb begin
      k        = {1'b0, mode1_q} + 3'd1;
      act_mask = '0;
      ch_i     = '0;
      ch_q     = '0;
      conv_i   = '0;
      conv_q   = '0;
      conv_err = '0;
      for (int b = 0; b < W; b++) begin
         act_mask[b] = (b < int'(k));
      end
      if (int'(k) > W) begin
         conv_err = '1;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            ch_i = ci1_q[c*W +: W];
            ch_q = cq1_q[c*W +: W];
            if ((|(ch_i & ~act_mask)) || (|(ch_q & ~act_mask))) begin
               conv_err[c] = 1'b1;
            end else begin
               conv_i[c*W +: W] = convert(ch_i, dir1_q);
               conv_q[c*W +: W] = convert(ch_q, dir1_q);
            end
         end
      end
   end

   // Next-state for both pipeline stages and the error counter. Data
   // registers only load alongside a valid transfer, so outputs hold
   // steady through a stall.
   always_comb begin
      v1_d    = accept || (v1_q && !s1_adv);
      mode1_d = mode1_q;
      dir1_d  = dir1_q;
      ci1_d   = ci1_q;
      cq1_d   = cq1_q;
      if (accept) begin
         mode1_d = i_mode;
         dir1_d  = i_dir;
         ci1_d   = i_code_i;
         cq1_d   = i_code_q;
      end

      v2_d   = s1_adv || (v2_q && !i_rdy);
      oi2_d  = oi2_q;
      oq2_d  = oq2_q;
      err2_d = err2_q;
      if (s1_adv) begin
         oi2_d  = conv_i;
         oq2_d  = conv_q;
         err2_d = conv_err;
      end

      // Clear wins over a coincident erroneous handshake
      cnt_d = cnt_q;
      if (i_err_clr) begin
         cnt_d = '0;
      end else if (v2_q && i_rdy && (|err2_q) && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q    <= 1'b0;
         mode1_q <= '0;
         dir1_q  <= 1'b0;
         ci1_q   <= '0;
         cq1_q   <= '0;
         v2_q    <= 1'b0;
         oi2_q   <= '0;
         oq2_q   <= '0;
         err2_q  <= '0;
         cnt_q   <= '0;
      end else begin
         v1_q    <= v1_d;
         mode1_q <= mode1_d;
         dir1_q  <= dir1_d;
         ci1_q   <= ci1_d;
         cq1_q   <= cq1_d;
         v2_q    <= v2_d;
         oi2_q   <= oi2_d;
         oq2_q   <= oq2_d;
         err2_q  <= err2_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_dv      = v2_q;
   assign o_code_i  = oi2_q;
   assign o_code_q  = oq2_q;
   assign o_err     = err2_q;
   assign o_err_cnt = cnt_q;

endmodule

// File: tb/tb_gray2bin_mc.sv
// ---------------------------------------------------------------------------
// tb_gray2bin_mc
//
// Testbench for gray2bin_mc. The main instance uses the default parameters
// and is checked beat by beat against a queue-based reference model. A
// second instance (MAX_ORDER=64, CNT_W=4) covers the unsupported-order case
// and counter saturation.
// ---------------------------------------------------------------------------
module tb_gray2bin_mc;

   typedef struct {
      logic [15:0] ci;
      logic [15:0] cq;
      logic [3:0]  err;
      int          age;
   } exp_t;

   logic        clk;
   logic        rst;

   // Main instance signals
   logic        i_dv, o_rdy, i_dir, o_dv, i_rdy, i_err_clr;
   logic [1:0]  i_mode;
   logic [15:0] i_code_i, i_code_q, o_code_i, o_code_q;
   logic [3:0]  o_err;
   logic [15:0] o_err_cnt;

   // Small instance signals
   logic        s_dv, s_o_rdy, s_dir, s_o_dv, s_rdy, s_clr;
   logic [1:0]  s_mode;
   logic [11:0] s_ci, s_cq, s_o_ci, s_o_cq;
   logic [3:0]  s_o_err;
   logic [3:0]  s_o_cnt;

   int   total;
   int   bad;
   int   cnt_exp;
   exp_t sb[$];

   gray2bin_mc dut (
      .clk       (clk),
      .rst       (rst),
      .i_dv      (i_dv),
      .o_rdy     (o_rdy),
      .i_mode    (i_mode),
      .i_dir     (i_dir),
      .i_code_i  (i_code_i),
      .i_code_q  (i_code_q),
      .o_dv      (o_dv),
      .i_rdy     (i_rdy),
      .o_code_i  (o_code_i),
      .o_code_q  (o_code_q),
      .o_err     (o_err),
      .i_err_clr (i_err_clr),
      .o_err_cnt (o_err_cnt)
   );

   gray2bin_mc #(.MAX_ORDER(64), .NUM_CH(4), .CNT_W(4)) dut_s (
      .clk       (clk),
      .rst       (rst),
      .i_dv      (s_dv),
      .o_rdy     (s_o_rdy),
      .i_mode    (s_mode),
      .i_dir     (s_dir),
      .i_code_i  (s_ci),
      .i_code_q  (s_cq),
      .o_dv      (s_o_dv),
      .i_rdy     (s_rdy),
      .o_code_i  (s_o_ci),
      .o_code_q  (s_o_cq),
      .o_err     (s_o_err),
      .i_err_clr (s_clr),
      .o_err_cnt (s_o_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Gray->binary by searching for the value whose Gray code matches
   function automatic int mapVal(input int a, input int k, input bit dir);
      if (dir) return a ^ (a >> 1);
      for (int v = 0; v < (1 << k); v++) begin
         if ((v ^ (v >> 1)) == a) return v;
      end
      return 0;
   endfunction

   // Expected result of one beat for the W=4 instance
   function automatic exp_t model(input logic [1:0] mode, input bit dir,
                                  input logic [15:0] ci, input logic [15:0] cq);
      exp_t e;
      int   k, a, b;
      k     = int'(mode) + 1;
      e.ci  = '0;
      e.cq  = '0;
      e.err = '0;
      e.age = 0;
      for (int c = 0; c < 4; c++) begin
         a = int'(ci >> (c * 4)) % 16;
         b = int'(cq >> (c * 4)) % 16;
         if (k > 4 || a >= (1 << k) || b >= (1 << k)) begin
            e.err[c] = 1'b1;
         end else begin
            e.ci = e.ci | 16'(mapVal(a, k, dir) << (c * 4));
            e.cq = e.cq | 16'(mapVal(b, k, dir) << (c * 4));
         end
      end
      return e;
   endfunction

   // Drive one cycle of main-instance inputs at the falling edge, check the
   // outputs against the model, then advance to the next falling edge
   task automatic applyStimulus(input bit dv, input logic [1:0] mode,
                                input bit dir, input logic [15:0] ci,
                                input logic [15:0] cq, input bit rdy,
                                input bit clr, output bit acc);
      bit   exp_dv;
      bit   hs_err;
      i_dv      = dv;
      i_mode    = mode;
      i_dir     = dir;
      i_code_i  = ci;
      i_code_q  = cq;
      i_rdy     = rdy;
      i_err_clr = clr;
      #1;
      exp_dv = (sb.size() > 0) && (sb[0].age >= 2);
      checkOutput("cnt", o_err_cnt, 64'(cnt_exp));
      checkOutput("rdy", o_rdy, 64'((sb.size() < 2) || rdy));
      checkOutput("dv", o_dv, 64'(exp_dv));
      hs_err = 1'b0;
      if (exp_dv) begin
         checkOutput("code_i", o_code_i, sb[0].ci);
         checkOutput("code_q", o_code_q, sb[0].cq);
         checkOutput("err", o_err, sb[0].err);
         if (rdy) begin
            hs_err = |sb[0].err;
            void'(sb.pop_front());
         end
      end
      if (clr) cnt_exp = 0;
      else if (hs_err && cnt_exp != 65535) cnt_exp++;
      acc = dv && o_rdy;
      if (acc) sb.push_back(model(mode, dir, ci, cq));
      @(posedge clk);
      foreach (sb[i]) sb[i].age++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) applyStimulus(0, 2'd0, 0, 16'h0, 16'h0, 1, 0, a);
   endtask

   function automatic logic [15:0] randCodes(input logic [1:0] mode);
      logic [15:0] r;
      int k, v;
      k = int'(mode) + 1;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         v = int'($urandom_range(0, (1 << k) - 1));
         if (k < 4 && $urandom_range(0, 9) == 0) v = v | (1 << $urandom_range(k, 3));
         r = r | 16'(v << (c * 4));
      end
      return r;
   endfunction

   initial begin
      bit          a;
      int          idx, stall_acc, hs;
      logic [15:0] bi[6];
      logic [15:0] bq[6];
      logic [1:0]  m;

      total = 0; bad = 0; cnt_exp = 0;
      i_dv = 0; i_mode = 0; i_dir = 0; i_code_i = 0; i_code_q = 0;
      i_rdy = 0; i_err_clr = 0;
      s_dv = 0; s_mode = 0; s_dir = 0; s_ci = 0; s_cq = 0; s_rdy = 1; s_clr = 0;

      // Reset state
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_dv", o_dv, 0);
      checkOutput("rst_ci", o_code_i, 0);
      checkOutput("rst_cq", o_code_q, 0);
      checkOutput("rst_err", o_err, 0);
      checkOutput("rst_cnt", o_err_cnt, 0);
      rst = 1'b1;

      // 16QAM Gray->binary on channel 0
      applyStimulus(1, 2'd1, 0, 16'h0003, 16'h0000, 1, 0, a);
      idle(3);

      // 256QAM both directions, back to back
      applyStimulus(1, 2'd3, 0, 16'h0008, 16'h0006, 1, 0, a);
      applyStimulus(1, 2'd3, 1, 16'h0005, 16'h0000, 1, 0, a);
      idle(3);

      // Illegal QPSK label on channel 2, then clear colliding with an error
      applyStimulus(1, 2'd0, 0, 16'h0200, 16'h0000, 1, 0, a);
      applyStimulus(1, 2'd0, 0, 16'h0200, 16'h0000, 1, 0, a);
      applyStimulus(0, 2'd0, 0, 16'h0000, 16'h0000, 1, 0, a);
      applyStimulus(0, 2'd0, 0, 16'h0000, 16'h0000, 1, 1, a);
      idle(2);

      // Backpressure: six beats with the sink stalled for four cycles
      for (int i = 0; i < 6; i++) begin
         bi[i] = randCodes(2'd3);
         bq[i] = randCodes(2'd3);
      end
      idx = 0;
      stall_acc = 0;
      for (int cyc = 0; cyc < 30 && idx < 6; cyc++) begin
         applyStimulus(1, 2'd3, idx[0], bi[idx], bq[idx], cyc >= 4, 0, a);
         if (a) begin
            idx++;
            if (cyc < 4) stall_acc++;
         end
      end
      checkOutput("bp_accepted", 64'(idx), 6);
      checkOutput("bp_stall_acc", 64'(stall_acc), 2);
      idle(4);

      // Unsupported order on the W=3 instance, counter saturation
      s_mode = 2'd3;
      hs = 0;
      for (int i = 0; i < 24; i++) begin
         s_dv  = (i < 20);
         s_dir = 1'($urandom);
         s_ci  = 12'($urandom);
         s_cq  = 12'($urandom);
         #1;
         checkOutput("s_rdy", s_o_rdy, 1);
         if (s_o_dv) begin
            checkOutput("s_err", s_o_err, 4'hF);
            checkOutput("s_ci", s_o_ci, 0);
            checkOutput("s_cq", s_o_cq, 0);
            hs++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      checkOutput("s_hs", 64'(hs), 20);
      checkOutput("s_cnt_sat", s_o_cnt, 15);
      s_dv = 0;

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         m = 2'($urandom);
         applyStimulus($urandom_range(0, 9) < 7, m, 1'($urandom),
                       randCodes(m), randCodes(m), $urandom_range(0, 9) < 7,
                       $urandom_range(0, 99) < 3, a);
      end
      idle(4);

      // Load a known error count, then reset with two beats buffered
      applyStimulus(1, 2'd0, 0, 16'h0020, 16'h0000, 1, 0, a);
      idle(3);
      applyStimulus(1, 2'd3, 1, 16'h0005, 16'h0000, 0, 0, a);
      applyStimulus(1, 2'd2, 0, 16'h0007, 16'h0000, 0, 0, a);
      applyStimulus(0, 2'd0, 0, 16'h0000, 16'h0000, 0, 0, a);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_dv", o_dv, 0);
      checkOutput("mid_rst_ci", o_code_i, 0);
      checkOutput("mid_rst_cq", o_code_q, 0);
      checkOutput("mid_rst_err", o_err, 0);
      checkOutput("mid_rst_cnt", o_err_cnt, 0);
      sb.delete();
      cnt_exp = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle(2);
      applyStimulus(1, 2'd2, 0, 16'h0007, 16'h0000, 1, 0, a);
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
